// File: rtl/dat_pkg.sv
// Shared definitions for the SD DAT-line datapath: FSM states and framing/CRC constants.
package dat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CRC,
    STOP
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        END_BIT    = 1'b1;
  localparam int          CRC16_LEN  = 16;

endpackage

// File: rtl/crc16_dat.sv
// Bit-serial CRC16-CCITT (0x1021) for a DAT line; shared with the receive-side checker.
module crc16_dat
  import dat_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[15];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          crc <= CRC16_INIT;
    else if (clear)     crc <= CRC16_INIT;
    else if (bit_valid) crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

endmodule

// File: rtl/dat_serializer.sv
// DAT-line transmitter: start bit, LSB-first payload, optional MSB-first CRC16, end bit.
module dat_serializer
  import dat_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int BITS_COUNTER = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [BITS_COUNTER-1:0] framesize,
  input  logic                    crc_en,
  input  logic [BITS-1:0]         data_in,
  output logic                    out,
  output logic                    busy,
  output logic                    complete
);

  localparam logic [BITS_COUNTER-1:0] MAX_LEN = BITS_COUNTER'(BITS);
  localparam logic [BITS_COUNTER-1:0] CRC_CNT = BITS_COUNTER'(CRC16_LEN);
  localparam logic [BITS_COUNTER-1:0] ONE     = BITS_COUNTER'(1);

  state_t                  state;
  logic [BITS-1:0]         shift;
  logic [BITS_COUNTER-1:0] counter;
  logic [BITS_COUNTER-1:0] flen;
  logic                    crc_on;
  logic [15:0]             crc;

  logic accept;
  logic send_data;
  logic send_crc;
  logic crc_valid;
  logic crc_bit;

  assign accept = enable && load && (state == IDLE);

  // START and DATA share one rule: counter holds payload bits already sent.
  assign send_data = ((state == START) || (state == DATA)) && (counter < flen);

  assign send_crc  = (((state == START) || (state == DATA)) && !send_data && crc_on) ||
                     ((state == CRC) && (counter < CRC_CNT));

  // Feeding crc[15] back makes fb zero, so the engine degenerates to a plain
  // left shift with zero fill while the checksum is being emitted.
  assign crc_valid = enable && (send_data || send_crc);
  assign crc_bit   = send_data ? shift[0] : crc[15];

  crc16_dat u_crc (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .bit_valid (crc_valid),
    .bit_in    (crc_bit),
    .crc       (crc)
  );

  // Only the MSB is consumed on the transmit side.
  logic unused_crc;
  assign unused_crc = ^crc[14:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      out      <= END_BIT;
      busy     <= 1'b0;
      complete <= 1'b0;
      counter  <= '0;
      shift    <= '0;
      flen     <= '0;
      crc_on   <= 1'b0;
    end else if (enable) begin
      complete <= 1'b0;
      case (state)
        IDLE: begin
          out <= END_BIT;
          if (load) begin
            shift   <= data_in;
            flen    <= (framesize > MAX_LEN) ? MAX_LEN : framesize;
            crc_on  <= crc_en;
            counter <= '0;
            out     <= START_BIT;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START, DATA: begin
          if (send_data) begin
            out     <= shift[0];
            shift   <= shift >> 1;
            counter <= counter + ONE;
            state   <= DATA;
          end else if (crc_on) begin
            out     <= crc[15];
            counter <= ONE;
            state   <= CRC;
          end else begin
            out   <= END_BIT;
            state <= STOP;
          end
        end
        CRC: begin
          if (counter < CRC_CNT) begin
            out     <= crc[15];
            counter <= counter + ONE;
          end else begin
            out   <= END_BIT;
            state <= STOP;
          end
        end
        STOP: begin
          out      <= END_BIT;
          busy     <= 1'b0;
          complete <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          out   <= END_BIT;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dat_serializer.sv
// Self-checking bench for dat_serializer: frame-level reference model plus directed literal checks.
module tb_dat_serializer;

  localparam int BITS = 32;
  localparam int BC   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            load = 1'b0;
  logic            crc_en = 1'b0;
  logic [BC-1:0]   framesize = '0;
  logic [BITS-1:0] data_in = '0;
  logic            out, busy, complete;

  int checks = 0;
  int fails  = 0;

  dat_serializer #(.BITS(BITS), .BITS_COUNTER(BC)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .framesize (framesize),
    .crc_en    (crc_en),
    .data_in   (data_in),
    .out       (out),
    .busy      (busy),
    .complete  (complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [BITS-1:0] d, input int n);
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < n; i++) begin
      logic fb = d[i] ^ c[15];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Reference model: an accepted load queues the whole frame's bit list; each
  // enabled edge presents the next bit, then one complete cycle follows.
  logic m_out = 1'b1, m_busy = 1'b0, m_cplt = 1'b0;
  bit   seq[$];

  function automatic void build_frame(input int fs, input logic [BITS-1:0] d, input logic ce);
    int f = (fs > BITS) ? BITS : fs;
    logic [15:0] c = crc_of(d, f);
    seq.delete();
    for (int i = 0; i < f; i++) seq.push_back(d[i]);
    if (ce) for (int i = 15; i >= 0; i--) seq.push_back(c[i]);
    seq.push_back(1'b1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out <= 1'b1; m_busy <= 1'b0; m_cplt <= 1'b0;
      seq.delete();
    end else if (enable) begin
      if (!m_busy && load) begin
        build_frame(int'(framesize), data_in, crc_en);
        m_out <= 1'b0; m_busy <= 1'b1; m_cplt <= 1'b0;
      end else if (seq.size() > 0) begin
        m_out <= seq.pop_front(); m_cplt <= 1'b0;
      end else if (m_busy) begin
        m_out <= 1'b1; m_busy <= 1'b0; m_cplt <= 1'b1;
      end else begin
        m_out <= 1'b1; m_cplt <= 1'b0;
      end
    end
  end

  logic cmp_on = 1'b0;
  always @(negedge clk)
    if (cmp_on) check("cycle {out,busy,complete}", {out, busy, complete}, {m_out, m_busy, m_cplt});

  // Directed frame capture: cap[k-1] holds out during cycle N+k.
  bit cap[$];
  int busy_cycles;

  function automatic logic [63:0] lsb_word(input int lo, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) if (lo + i < cap.size()) v[i] = cap[lo + i];
    return v;
  endfunction

  function automatic logic [63:0] msb_word(input int lo, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], (lo + i < cap.size()) ? cap[lo + i] : 1'b0};
    return v;
  endfunction

  function automatic logic cap_at(input int i);
    return (i < cap.size()) ? cap[i] : 1'bx;
  endfunction

  task automatic run_frame(input int fs, input logic [BITS-1:0] d, input logic ce,
                           input int stall_at, input int load_at, output int k_done);
    @(negedge clk);
    framesize = BC'(fs); data_in = d; crc_en = ce; load = 1'b1; enable = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cap.delete(); busy_cycles = 0; k_done = -1;
    for (int k = 1; k <= 200; k++) begin
      cap.push_back(out);
      if (busy) busy_cycles++;
      if (complete) begin k_done = k; break; end
      enable = !(stall_at > 0 && k >= stall_at && k < stall_at + 3);
      load   = (k == load_at);
      @(negedge clk);
    end
    load = 1'b0; enable = 1'b1;
    if (k_done < 0) check("frame_done_within_budget", complete, 1'b1);
  endtask

  initial begin
    int kd;
    int seen;

    check("crc_model_single_one", crc_of(32'h1, 1), 16'h1021);
    check("crc_model_byte_01",    crc_of(32'h1, 8), 16'h9188);

    repeat (3) @(negedge clk);
    check("reset_out", out, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_complete", complete, 1'b0);
    reset = 1'b0; enable = 1'b1;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);

    // framesize=1, data=1, CRC on
    run_frame(1, 32'h1, 1'b1, 0, 0, kd);
    check("f1_start", cap_at(0), 1'b0);
    check("f1_payload", cap_at(1), 1'b1);
    check("f1_crc", msb_word(2, 16), 16'h1021);
    check("f1_end", cap_at(18), 1'b1);
    check("f1_complete_cycle", kd, 20);

    // framesize=8, data=0x01, CRC on
    run_frame(8, 32'h01, 1'b1, 0, 0, kd);
    check("f8_payload", lsb_word(1, 8), 8'h01);
    check("f8_crc", msb_word(9, 16), 16'h9188);
    check("f8_end", cap_at(25), 1'b1);
    check("f8_busy_cycles", busy_cycles, 26);

    // Loopback into an LSB-first deserializer, no CRC
    run_frame(32, 32'hA5A5F00F, 1'b0, 0, 0, kd);
    check("loop_word", lsb_word(1, 32), 32'hA5A5F00F);
    check("loop_end", cap_at(33), 1'b1);
    check("loop_complete_cycle", kd, 35);

    // 3-cycle suspend mid-payload plus a load while busy
    run_frame(8, 32'hB4, 1'b0, 4, 6, kd);
    check("stall_complete_cycle", kd, 14);
    for (int i = 0; i < 3; i++) cap.delete(4);
    check("stall_payload", lsb_word(1, 8), 8'hB4);
    check("stall_end", cap_at(9), 1'b1);
    @(negedge clk);
    check("stall_no_queued_frame", busy, 1'b0);
    @(negedge clk);
    check("stall_still_idle", busy, 1'b0);

    // framesize above BITS clamps
    run_frame(40, 32'hDEADBEEF, 1'b0, 0, 0, kd);
    check("clamp_word", lsb_word(1, 32), 32'hDEADBEEF);
    check("clamp_complete_cycle", kd, 35);

    // framesize=0 with CRC
    run_frame(0, 32'hFFFFFFFF, 1'b1, 0, 0, kd);
    check("f0_start", cap_at(0), 1'b0);
    check("f0_crc_zero", msb_word(1, 16), 16'h0000);
    check("f0_end", cap_at(17), 1'b1);
    check("f0_complete_cycle", kd, 19);

    // Reset mid-frame: out high immediately, frame abandoned
    @(negedge clk);
    framesize = 8'd16; data_in = '0; crc_en = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_out_low", out, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out", out, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (complete) seen++;
    end
    check("no_complete_after_reset", seen, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      enable    = ($urandom_range(0, 7) != 0);
      load      = ($urandom_range(0, 3) == 0);
      framesize = BC'($urandom_range(0, 40));
      crc_en    = 1'($urandom_range(0, 1));
      data_in   = $urandom;
    end
    @(negedge clk);
    load = 1'b0; enable = 1'b1;
    for (int c = 0; c < 100 && (busy || complete); c++) @(negedge clk);
    check("drain_idle", {busy, complete}, 2'b00);

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
